pc_fetch_unit: RTL

- Program-counter register and next-PC selector for the IF stage of the 5-stage MIPS pipeline.
- Drives PC_Out to instruction memory and to the +4 adder, then consumes the adder's sum back on PCPlus4_In.
- Arbitrates sequential fetch, branch redirect (resolved in EX), jump redirect (resolved in ID) and PC stall.
- Holds a redirect that arrives during a stall until the stall releases, and flushes IF/ID on every applied redirect.

---
 rtl/pc_fetch_if.sv | 26 ++
 rtl/pc_fetch_unit.sv | 105 ++++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: IF-stage next-PC bus between the fetch unit and its
// neighbours (adder, hazard unit, ID/EX redirect sources, I-mem).
interface pc_fetch_if;
   logic        Stall_PC;
   logic [31:0] PCPlus4_In;
   logic        Branch_Taken;
   logic [31:0] Branch_Target;
   logic        Jump;
   logic [31:0] Jump_Target;
   logic [31:0] PC_Out;
   logic        Flush_IFID;
   logic        Fetch_Valid;
   logic        Redirect_Pending;
   logic        Misalign_Err;
   logic [31:0] Fetch_Count;

   modport slave (
      input  Stall_PC, PCPlus4_In, Branch_Taken, Branch_Target, Jump, Jump_Target,
      output PC_Out, Flush_IFID, Fetch_Valid, Redirect_Pending, Misalign_Err, Fetch_Count
   );

   modport master (
      output Stall_PC, PCPlus4_In, Branch_Taken, Branch_Target, Jump, Jump_Target,
      input  PC_Out, Flush_IFID, Fetch_Valid, Redirect_Pending, Misalign_Err, Fetch_Count
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and next-PC arbitration for the IF stage.
// Optional fetch counter enabled by defining PC_FETCH_COUNT_EN; without it
// Fetch_Count is tied to zero.
//
// state | meaning
// RUN   | normal sequential fetch, redirects applied immediately
// HOLD  | stalled with no redirect outstanding
// PEND  | stalled with a redirect latched, applied on stall release
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic       Clk,
   input logic       Rst,
   pc_fetch_if.slave bus
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HOLD = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_pend_tgt;
   logic        r_flush;
   logic        r_fv;
   logic        r_rp;
   logic        r_mis;

   logic        w_redirect;
   logic [31:0] w_sel_tgt;
   logic        w_fv_next;

   // Branch wins over jump: the branch belongs to the older instruction.
   assign w_redirect = bus.Branch_Taken | bus.Jump;
   assign w_sel_tgt  = bus.Branch_Taken ? bus.Branch_Target : bus.Jump_Target;
   assign w_fv_next  = (r_state != ST_PEND) && !w_redirect && !bus.Stall_PC;

   // Main FSM: PC update, redirect latching and registered status outputs.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_PC;
         r_pend_tgt <= 32'h0;
         r_flush    <= 1'b0;
         r_fv       <= 1'b0;
         r_rp       <= 1'b0;
         r_mis      <= 1'b0;
      end else begin
         r_flush <= 1'b0;
         r_fv    <= w_fv_next;
         case (r_state)
            ST_PEND: begin
               // Redirects seen while pending come from a squashed path.
               if (!bus.Stall_PC) begin
                  r_pc    <= {r_pend_tgt[31:2], 2'b00};
                  r_flush <= 1'b1;
                  r_rp    <= 1'b0;
                  r_state <= ST_RUN;
                  if (|r_pend_tgt[1:0]) r_mis <= 1'b1;
               end
            end
            default: begin
               if (w_redirect && !bus.Stall_PC) begin
                  r_pc    <= {w_sel_tgt[31:2], 2'b00};
                  r_flush <= 1'b1;
                  r_state <= ST_RUN;
                  if (|w_sel_tgt[1:0]) r_mis <= 1'b1;
               end else if (w_redirect) begin
                  r_pend_tgt <= w_sel_tgt;
                  r_rp       <= 1'b1;
                  r_state    <= ST_PEND;
               end else if (bus.Stall_PC) begin
                  r_state <= ST_HOLD;
               end else begin
                  r_pc    <= bus.PCPlus4_In;
                  r_state <= ST_RUN;
               end
            end
         endcase
      end
   end

   assign bus.PC_Out           = r_pc;
   assign bus.Flush_IFID       = r_flush;
   assign bus.Fetch_Valid      = r_fv;
   assign bus.Redirect_Pending = r_rp;
   assign bus.Misalign_Err     = r_mis;

`ifdef PC_FETCH_COUNT_EN
   logic [31:0] r_fetch_cnt;

   // Count every edge on which Fetch_Valid is (re)asserted; wraps naturally.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) r_fetch_cnt <= 32'h0;
      else if (w_fv_next) r_fetch_cnt <= r_fetch_cnt + 32'd1;
   end

   assign bus.Fetch_Count = r_fetch_cnt;
`else
   assign bus.Fetch_Count = 32'h0;
`endif

endmodule
